// File: rtl/rd_control.sv
// rd_control: skewed read address/enable generator for the systolic array input buffer.
// Lane i starts i cycles after lane 0; every lane reads len words upward from base_addr.
module rd_control #(
  parameter int unsigned WIDTH_HEIGHT = 4,
  parameter int unsigned ADDR_W       = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic [ADDR_W-1:0]              base_addr,
  input  logic [ADDR_W-1:0]              len,
  input  logic                           pause,
  output logic [WIDTH_HEIGHT-1:0]        rd_en,
  output logic [WIDTH_HEIGHT*ADDR_W-1:0] rd_addr,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                         state;
  // cnt holds the index of the next step to be emitted, not the one on the outputs
  logic [CNT_W-1:0]               cnt;
  logic [ADDR_W-1:0]              base_q;
  logic [ADDR_W-1:0]              len_q;

  logic [ADDR_W-1:0]              cur_base;
  logic [ADDR_W-1:0]              cur_len;
  logic [CNT_W-1:0]               emit_cnt;
  logic [CNT_W-1:0]               end_cnt;
  logic [WIDTH_HEIGHT-1:0]        lane_en;
  logic [WIDTH_HEIGHT*ADDR_W-1:0] lane_addr;

  // Per-lane enable/address for the step about to be registered; IDLE uses the live inputs
  always_comb begin
    cur_base  = (state == ST_IDLE) ? base_addr : base_q;
    cur_len   = (state == ST_IDLE) ? len : len_q;
    emit_cnt  = (state == ST_IDLE) ? '0 : cnt;
    end_cnt   = CNT_W'(len_q) + CNT_W'(WIDTH_HEIGHT - 1);
    lane_en   = '0;
    lane_addr = '0;
    for (int i = 0; i < int'(WIDTH_HEIGHT); i++) begin
      lane_en[i] = (emit_cnt >= CNT_W'(i)) &&
                   (emit_cnt < (CNT_W'(i) + CNT_W'(cur_len)));
      if (lane_en[i]) begin
        lane_addr[i*ADDR_W +: ADDR_W] = cur_base + ADDR_W'(emit_cnt - CNT_W'(i));
      end
    end
  end

  // Sequencer FSM with registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      base_q  <= '0;
      len_q   <= '0;
      rd_en   <= '0;
      rd_addr <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done    <= 1'b0;
      rd_en   <= '0;
      rd_addr <= '0;
      case (state)
        ST_IDLE: begin
          busy <= 1'b0;
          if (start) begin
            if (len != '0) begin
              base_q  <= base_addr;
              len_q   <= len;
              cnt     <= CNT_W'(1);
              rd_en   <= lane_en;
              rd_addr <= lane_addr;
              busy    <= 1'b1;
              state   <= ST_RUN;
            end else begin
              done  <= 1'b1;
              state <= ST_DONE;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            busy <= 1'b1;
          end else if (cnt == end_cnt) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            cnt   <= '0;
            state <= ST_DONE;
          end else begin
            busy    <= 1'b1;
            rd_en   <= lane_en;
            rd_addr <= lane_addr;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          cnt   <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_control.sv
// tb_rd_control: directed scenarios plus randomized traffic against a step-based reference model.
module tb_rd_control;

  localparam int unsigned WH = 4;
  localparam int unsigned AW = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic              pause;
  logic [AW-1:0]     base_addr;
  logic [AW-1:0]     len;
  logic [WH-1:0]     rd_en;
  logic [WH*AW-1:0]  rd_addr;
  logic              busy;
  logic              done;

  int total = 0;
  int bad   = 0;

  // reference model: mode 0 idle, 1 running, 2 done; m_k = next step index to show
  int m_mode = 0;
  int m_base = 0;
  int m_len  = 0;
  int m_k    = 0;
  logic [WH-1:0]    e_en;
  logic [WH*AW-1:0] e_addr;
  logic             e_busy;
  logic             e_done;

  rd_control #(.WIDTH_HEIGHT(WH), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .len(len),
    .pause(pause), .rd_en(rd_en), .rd_addr(rd_addr), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // step k: lane i active for k in [i, i+len), reading base + (k-i) mod 2^AW
  function automatic void show_step(input int k);
    for (int i = 0; i < int'(WH); i++) begin
      if (k >= i && k < i + m_len) begin
        e_en[i] = 1'b1;
        e_addr[i*AW +: AW] = AW'((m_base + k - i) % (1 << AW));
      end
    end
  endfunction

  // predict outputs after the coming edge from the inputs presently driven
  task automatic model_edge();
    e_en = '0; e_addr = '0; e_busy = 1'b0; e_done = 1'b0;
    if (reset) begin
      m_mode = 0;
    end else begin
      case (m_mode)
        0: if (start) begin
             if (len == 0) begin
               e_done = 1'b1; m_mode = 2;
             end else begin
               m_base = int'(base_addr); m_len = int'(len);
               show_step(0); e_busy = 1'b1; m_k = 1; m_mode = 1;
             end
           end
        1: if (pause) begin
             e_busy = 1'b1;
           end else if (m_k == m_len + int'(WH) - 1) begin
             e_done = 1'b1; m_mode = 2;
           end else begin
             show_step(m_k); e_busy = 1'b1; m_k++;
           end
        default: m_mode = 0;
      endcase
    end
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_val("rd_en", 64'(rd_en), 64'(e_en));
    check_val("rd_addr", 64'(rd_addr), 64'(e_addr));
    check_val("busy", 64'(busy), 64'(e_busy));
    check_val("done", 64'(done), 64'(e_done));
  endtask

  logic [WH-1:0]    basic_en [6];
  logic [WH*AW-1:0] basic_ad [6];
  logic [AW-1:0]    wrap_seq [4];

  initial begin
    basic_en = '{4'b0001, 4'b0011, 4'b0111, 4'b1110, 4'b1100, 4'b1000};
    basic_ad = '{32'h0000_0010, 32'h0000_1011, 32'h0010_1112,
                 32'h1011_1200, 32'h1112_0000, 32'h1200_0000};
    wrap_seq = '{8'hFE, 8'hFF, 8'h00, 8'h01};

    // reset held with start asserted
    reset = 1'b1; start = 1'b1; pause = 1'b0; base_addr = 8'h55; len = 8'd3;
    repeat (2) begin
      cycle();
      check_val("rst_busy", 64'(busy), 64'd0);
    end
    reset = 1'b0; start = 1'b0;
    cycle();
    check_val("idle_en", 64'(rd_en), 64'd0);

    // basic base=0x10 len=3
    base_addr = 8'h10; len = 8'd3; start = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cycle();
      start = 1'b0;
      check_val("basic_en", 64'(rd_en), 64'(basic_en[c]));
      check_val("basic_addr", 64'(rd_addr), 64'(basic_ad[c]));
    end
    cycle();
    check_val("basic_done", 64'(done), 64'd1);
    check_val("basic_busy", 64'(busy), 64'd0);
    cycle();
    check_val("basic_done_1cyc", 64'(done), 64'd0);

    // wrap base=0xFE len=4
    base_addr = 8'hFE; len = 8'd4; start = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cycle();
      start = 1'b0;
      if (c < 4) check_val("wrap_lane0", 64'(rd_addr[7:0]), 64'(wrap_seq[c]));
      if (c >= 3 && c < 7) check_val("wrap_lane3", 64'(rd_addr[31:24]), 64'(wrap_seq[c-3]));
      check_val("wrap_done", 64'(done), (c == 7) ? 64'd1 : 64'd0);
    end
    cycle();

    // zero length
    len = 8'd0; start = 1'b1;
    cycle();
    start = 1'b0;
    check_val("zero_done", 64'(done), 64'd1);
    check_val("zero_busy", 64'(busy), 64'd0);
    check_val("zero_en", 64'(rd_en), 64'd0);
    cycle();
    cycle();

    // pause and ignored start
    base_addr = 8'h00; len = 8'd2; start = 1'b1;
    cycle();
    start = 1'b0;
    cycle();
    check_val("pause_pre", 64'(rd_en), 64'b0011);
    pause = 1'b1;
    cycle();
    check_val("pause_z1", 64'(rd_en), 64'd0);
    cycle();
    check_val("pause_z2", 64'(rd_addr), 64'd0);
    pause = 1'b0; start = 1'b1; base_addr = 8'h80;
    cycle();
    start = 1'b0;
    check_val("pause_resume_en", 64'(rd_en), 64'b0110);
    check_val("pause_resume_addr", 64'(rd_addr), 64'h0000_0100);
    repeat (4) cycle();

    // reset mid-run then replay
    base_addr = 8'h20; len = 8'd8; start = 1'b1;
    cycle();
    start = 1'b0;
    repeat (3) cycle();
    check_val("mid_full", 64'(rd_en), 64'b1111);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    check_val("mid_rst_en", 64'(rd_en), 64'd0);
    check_val("mid_rst_done", 64'(done), 64'd0);
    cycle();
    cycle();
    start = 1'b1;
    cycle();
    start = 1'b0;
    check_val("replay_en", 64'(rd_en), 64'b0001);
    check_val("replay_addr", 64'(rd_addr[7:0]), 64'h20);
    repeat (12) cycle();

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      reset     = ($urandom_range(0, 199) == 0);
      start     = ($urandom_range(0, 3) == 0);
      pause     = ($urandom_range(0, 4) == 0);
      base_addr = AW'($urandom);
      case ($urandom_range(0, 15))
        0, 1:    len = 8'd0;
        2:       len = AW'($urandom);
        default: len = AW'($urandom_range(1, 12));
      endcase
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_control.md
Name: rd_control

Overview:
- Read-side address/enable generator for the systolic array input buffer.
- Produces the diagonally skewed read pattern that feeds a WIDTH_HEIGHT-lane array. Lane i starts i cycles after lane 0, and each lane reads LEN consecutive words from base_addr upward.
- Sits between the top-level sequencer (start/done handshake) and the per-lane input memory banks.

Parameters:
- WIDTH_HEIGHT, 4, number of lanes (array rows); also the skew depth.
- ADDR_W, 8, per-lane address width in bits.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request to begin one read sequence; sampled only in IDLE.
- base_addr  input  ADDR_W  first word address for every lane; latched on accepted start.
- len  input  ADDR_W  words per lane (0..2^ADDR_W-1); latched on accepted start.
- pause  input  1  freeze the sequence for the following cycle.
- rd_en  output  WIDTH_HEIGHT  per-lane read enable; bit i = lane i.
- rd_addr  output  WIDTH_HEIGHT*ADDR_W  packed per-lane addresses; lane i at bits [i*ADDR_W +: ADDR_W].
- busy  output  1  high while a sequence is in RUN.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- All outputs are registered.
- Reset values: rd_en=0, rd_addr=0, busy=0, done=0. State=IDLE, cycle counter cnt=0, latched base/len=0.
- States are IDLE, RUN and DONE.
- IDLE:
  - start=1 with len!=0 -> latch base_addr and len, cnt=0, go to RUN.
  - Outputs in the next cycle: rd_en[0]=1, lane0 addr=base, busy=1.
  - start=1 with len==0 -> go straight to DONE; no rd_en is ever asserted.
- RUN, cycle-level rules:
  - Lane i enable: rd_en[i] = (cnt >= i) && (cnt < i+len).
  - Lane i address: base + (cnt - i), modulo 2^ADDR_W, when enabled; 0 when not enabled.
  - cnt advances 0 .. len+WIDTH_HEIGHT-2, i.e. len+WIDTH_HEIGHT-1 enabled cycles in total.
  - After the cycle with cnt = len+WIDTH_HEIGHT-2, go to DONE.
- DONE:
  - Lasts exactly one cycle: done=1, busy=0, rd_en=0, rd_addr=0.
  - Then return to IDLE.
  - start during DONE is ignored; the earliest new start is sampled in the cycle after done.
- pause:
  - pause=1 sampled at an edge in RUN -> the following cycle has rd_en=0 and rd_addr=0, with cnt held.
  - Sequence resumes exactly where it stopped once pause=0; relative skew between lanes is preserved.
  - pause has no effect in IDLE or DONE.
- start while busy is ignored; the latched base/len are unaffected.
- Address arithmetic is ADDR_W-bit unsigned and wraps silently.
- cnt needs ADDR_W+1 bits (max len+WIDTH_HEIGHT-2).
- Reset mid-sequence: next cycle all outputs 0, state IDLE, no done pulse.
- Reset has priority over start and pause in the same cycle.

Test Plan:
- Reset: hold reset 2 cycles with start=1 -> rd_en=0, rd_addr=0, busy=0, done=0 throughout; no sequence begins.
- Basic, base=0x10, len=3: pulse start.
  - Next cycle: rd_en=0001, lane0=0x10.
  - Then 0011 (lane0=0x11, lane1=0x10).
  - Then 0111 (lane0=0x12, lane1=0x11, lane2=0x10).
  - Then 1110 (lane1=0x12, lane2=0x11, lane3=0x10).
  - Then 1100 (lane2=0x12, lane3=0x11).
  - Then 1000 (lane3=0x12).
  - Then done=1, busy=0 for one cycle.
- Wrap, base=0xFE, len=4: lane0 addresses FE, FF, 00, 01 on consecutive cycles; lane3 shows the same sequence 3 cycles later. done after 7 enabled cycles.
- Zero length, len=0: start -> rd_en never set, busy never set, done=1 in the cycle after start.
- Pause and ignored start, base=0x00, len=2:
  - Assert pause for 2 cycles when rd_en=0011 -> two cycles of rd_en=0, then 0110 (lane1=0x01, lane2=0x00) continues.
  - Pulse start with base=0x80 mid-run -> ignored; the addresses stay in the 0x00 sequence.
- Reset mid-run, base=0x20, len=8: assert reset when rd_en=1111 -> next cycle all outputs 0, no done pulse. A new start two cycles later replays from lane0=base.
